// File: rtl/leaf_out_port_ctrl_pkg.sv
// Shared definitions for the leaf output-port packetizer: default field widths,
// packet layout positions, port-number bounds and the port FSM state type.
package leaf_out_port_ctrl_pkg;

  localparam int PKT_BITS        = 97;
  localparam int PKT_LEAF_BITS   = 6;
  localparam int PKT_PORT_BITS   = 4;
  localparam int PKT_ADDR_BITS   = 7;
  localparam int PKT_PAYLOAD_BITS = 64;

  // Header is packed MSB-first: valid, leaf, port, zero pad, addr, then payload.
  localparam int PKT_VALID_POS   = PKT_BITS - 1;
  localparam int PKT_LEAF_LSB    = PKT_VALID_POS - PKT_LEAF_BITS;
  localparam int PKT_PORT_LSB    = PKT_LEAF_LSB - PKT_PORT_BITS;
  localparam int PKT_ADDR_LSB    = PKT_PAYLOAD_BITS;
  localparam int PKT_PAYLOAD_LSB = 0;

  localparam int OUTPUT_PORT_MIN_NUM = 9;
  localparam int INPUT_PORT_MAX_NUM  = 8;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } out_port_state_e;

endpackage

// File: rtl/leaf_out_port_ctrl_credit_cnt.sv
// Load/add/sub credit counter with saturation on add; shared by the output
// port and the input-side freespace tracking.
module out_port_credit_cnt #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (inc && !dec) begin
      if (cnt != '1) cnt <= cnt + WIDTH'(1);
    end else if (dec && !inc) begin
      // Callers only decrement with credit available; the guard keeps it from wrapping.
      if (cnt != '0) cnt <= cnt - WIDTH'(1);
    end
  end

endmodule

// File: rtl/leaf_out_port_ctrl.sv
// Per-output-port packetizer and credit manager for a leaf.
// Optional OUT_PORT_STATS_EN adds sent_cnt/stall_cnt statistics outputs.
module leaf_out_port_ctrl
  import leaf_out_port_ctrl_pkg::*;
#(
  parameter int PACKET_BITS   = PKT_BITS,
  parameter int NUM_LEAF_BITS = PKT_LEAF_BITS,
  parameter int NUM_PORT_BITS = PKT_PORT_BITS,
  parameter int NUM_ADDR_BITS = PKT_ADDR_BITS,
  parameter int PAYLOAD_BITS  = PKT_PAYLOAD_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] dst_port,
  input  logic [NUM_ADDR_BITS-1:0] bram_addr,
  input  logic [NUM_ADDR_BITS-1:0] freespace,
  input  logic                     update_freespace_en,
  input  logic                     update_bram_addr_en,
  input  logic                     add_freespace_en,
  input  logic [PAYLOAD_BITS-1:0]  din,
  input  logic                     din_vld,
  output logic                     din_rdy,
  output logic [PACKET_BITS-1:0]   packet_out,
  output logic                     packet_vld,
  input  logic                     packet_rdy,
`ifdef OUT_PORT_STATS_EN
  output logic [NUM_ADDR_BITS-1:0] credit_cnt,
  output logic [31:0]              sent_cnt,
  output logic [31:0]              stall_cnt
`else
  output logic [NUM_ADDR_BITS-1:0] credit_cnt
`endif
);

  localparam int LEAF_LSB = PACKET_BITS - 1 - NUM_LEAF_BITS;
  localparam int PORT_LSB = LEAF_LSB - NUM_PORT_BITS;

  out_port_state_e state, state_next;
  logic [NUM_ADDR_BITS-1:0] cred;
  logic [NUM_ADDR_BITS-1:0] addr;
  logic [PACKET_BITS-1:0]   pkt_next;
  logic                     send;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= UNCFG;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == UNCFG && update_freespace_en) state_next = RUN;
  end

  // The output slot is free when empty or being drained this cycle.
  assign din_rdy    = (state == RUN) && (cred != '0) && (!packet_vld || packet_rdy);
  assign send       = din_vld && din_rdy;
  assign credit_cnt = cred;

  out_port_credit_cnt #(
    .WIDTH (NUM_ADDR_BITS)
  ) u_credit_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (update_freespace_en),
    .load_val (freespace),
    .inc      (add_freespace_en),
    .dec      (send),
    .cnt      (cred)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   addr <= '0;
    else if (update_bram_addr_en) addr <= bram_addr;
    else if (send)                addr <= addr + NUM_ADDR_BITS'(1);
  end

  always_comb begin
    pkt_next                                  = '0;
    pkt_next[PACKET_BITS-1]                   = 1'b1;
    pkt_next[LEAF_LSB +: NUM_LEAF_BITS]       = dst_leaf;
    pkt_next[PORT_LSB +: NUM_PORT_BITS]       = dst_port;
    pkt_next[PAYLOAD_BITS +: NUM_ADDR_BITS]   = addr;
    pkt_next[PAYLOAD_BITS-1:0]                = din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      packet_out <= '0;
      packet_vld <= 1'b0;
    end else if (send) begin
      packet_out <= pkt_next;
      packet_vld <= 1'b1;
    end else if (packet_rdy) begin
      packet_vld <= 1'b0;
    end
  end

`ifdef OUT_PORT_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sent_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (send) sent_cnt <= sent_cnt + 32'd1;
      if (state == RUN && din_vld && !din_rdy) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
